// File: rtl/dct_eo_stream_split.sv
// dct_eo_stream_split: assembles N-sample blocks from a stream and emits them as
// even/odd halves (MODE 0) or first-stage DCT butterfly sums/differences (MODE 1).
module dct_eo_stream_split #(
  parameter int W = 8,
  parameter int N = 8,
  parameter int MODE = 0,
  localparam int OW = (MODE == 1) ? W + 1 : W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(N/2)*OW-1:0]  out_a,
  output logic [(N/2)*OW-1:0]  out_b,
  output logic                 sync_err
);
  localparam int CW = $clog2(N);
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [W-1:0] buf_q [N-1];
  logic [W-1:0] x [N];
  logic [(N/2)*OW-1:0] a_q, b_q, a_d, b_d;
  logic ov_q, ov_d, se_q, acc, last, resync;
  assign in_ready = !(cnt_q == CW'(N-1) && ov_q && !out_ready);
  always_comb begin
    acc = in_valid && in_ready;
    idx = in_first ? '0 : cnt_q;
    last = acc && idx == CW'(N-1);
    resync = acc && in_first && cnt_q != '0;
    cnt_d = acc ? (last ? '0 : idx + CW'(1)) : cnt_q;
    ov_d = last || (ov_q && !out_ready);
  end
  // The final sample bypasses the buffer so the block loads on its own accept edge.
  always_comb begin
    for (int i = 0; i < N-1; i++) x[i] = buf_q[i];
    x[N-1] = in_data;
  end
  for (genvar k = 0; k < N/2; k++) begin : g_lane
    if (MODE == 1) begin : g_bf
      assign a_d[k*OW +: OW] = OW'(signed'(x[k])) + OW'(signed'(x[N-1-k]));
      assign b_d[k*OW +: OW] = OW'(signed'(x[k])) - OW'(signed'(x[N-1-k]));
    end else begin : g_pm
      assign a_d[k*OW +: OW] = x[2*k];
      assign b_d[k*OW +: OW] = x[2*k+1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ov_q <= 1'b0;
      se_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < N-1; i++) buf_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      se_q <= resync;
      if (acc && !last) buf_q[idx] <= in_data;
      if (last) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end
  assign out_valid = ov_q;
  assign out_a = a_q;
  assign out_b = b_q;
  assign sync_err = se_q;
endmodule

// File: tb/tb_dct_eo_stream_split.sv
// tb_dct_eo_stream_split: directed checks of permute (u0) and butterfly (u1) instances
// driven by one shared input stream.
module tb_dct_eo_stream_split;
  logic clk = 0, rst = 1, in_valid = 0, in_first = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic rdy0, ov0, se0, rdy1, ov1, se1;
  logic [31:0] a0, b0;
  logic [35:0] a1, b1;
  int n_chk = 0, n_fail = 0, pulses = 0;
  always #5 clk = ~clk;
  dct_eo_stream_split #(.W(8), .N(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_first(in_first), .out_valid(ov0), .out_ready(out_ready), .out_a(a0),
    .out_b(b0), .sync_err(se0));
  dct_eo_stream_split #(.W(8), .N(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_first(in_first), .out_valid(ov1), .out_ready(out_ready), .out_a(a1),
    .out_b(b1), .sync_err(se1));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic f);
    in_valid = 1; in_data = d; in_first = f;
    #1 chk("send_ready", rdy0, 1'b1);
    @(posedge clk); #1;
    in_valid = 0; in_first = 0;
  endtask
  task automatic drain();
    out_ready = 1;
    @(posedge clk); #1;
    chk("drain_ov0", ov0, 1'b0);
    chk("drain_ov1", ov1, 1'b0);
    out_ready = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ov", ov0, 1'b0);
    chk("rst_a", a0, 32'h0);
    chk("rst_b", b0, 32'h0);
    chk("rst_se", se0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    // T1 permute
    for (int i = 1; i <= 7; i++) send(8'(i), i == 1);
    chk("t1_ov_early", ov0, 1'b0);
    send(8'd8, 1'b0);
    chk("t1_ov", ov0, 1'b1);
    chk("t1_a", a0, {8'd7, 8'd5, 8'd3, 8'd1});
    chk("t1_b", b0, {8'd8, 8'd6, 8'd4, 8'd2});
    drain();
    // T2 butterfly on u1, permute cross-check on u0
    for (int i = 1; i <= 8; i++) send(8'(10*i), i == 1);
    chk("t2_ov1", ov1, 1'b1);
    chk("t2_a1", a1, {4{9'd90}});
    chk("t2_b1", b1, {9'd502, 9'd482, 9'd462, 9'd442});
    chk("t2_a0", a0, {8'd70, 8'd50, 8'd30, 8'd10});
    chk("t2_b0", b0, {8'd80, 8'd60, 8'd40, 8'd20});
    drain();
    // T3 backpressure: block 2 stalls on its last sample
    for (int i = 1; i <= 8; i++) send(8'(10+i), i == 1);
    for (int i = 1; i <= 7; i++) send(8'(20+i), i == 1);
    chk("t3_a_hold", a0, {8'd17, 8'd15, 8'd13, 8'd11});
    in_valid = 1; in_data = 8'd28;
    #1 chk("t3_stall", rdy0, 1'b0);
    @(posedge clk); #1;
    chk("t3_stall2", rdy0, 1'b0);
    chk("t3_a_stable", a0, {8'd17, 8'd15, 8'd13, 8'd11});
    chk("t3_b_stable", b0, {8'd18, 8'd16, 8'd14, 8'd12});
    out_ready = 1;
    #1 chk("t3_unstall", rdy0, 1'b1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("t3_ov_kept", ov0, 1'b1);
    chk("t3_a2", a0, {8'd27, 8'd25, 8'd23, 8'd21});
    chk("t3_b2", b0, {8'd28, 8'd26, 8'd24, 8'd22});
    @(posedge clk); #1;
    chk("t3_ov_clr", ov0, 1'b0);
    out_ready = 0;
    // T4 resync after 3 samples
    for (int i = 1; i <= 3; i++) send(8'(i), i == 1);
    chk("t4_se_pre", se0, 1'b0);
    send(8'd9, 1'b1);
    chk("t4_se", se0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(8'(100+i), 1'b0);
      if (i == 0) chk("t4_se_clr", se0, 1'b0);
    end
    chk("t4_ov", ov0, 1'b1);
    chk("t4_a", a0, {8'd105, 8'd103, 8'd101, 8'd9});
    chk("t4_b", b0, {8'd106, 8'd104, 8'd102, 8'd100});
    drain();
    // T5 reset mid-block
    for (int i = 1; i <= 5; i++) send(8'(i), i == 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t5_ov", ov0, 1'b0);
    chk("t5_a", a0, 32'h0);
    chk("t5_b", b0, 32'h0);
    for (int i = 1; i <= 8; i++) send(8'(30+i), 1'b0);
    chk("t5_ov2", ov0, 1'b1);
    chk("t5_a2", a0, {8'd37, 8'd35, 8'd33, 8'd31});
    chk("t5_se", se0, 1'b0);
    drain();
    // T6 full throughput
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 8'(40+i); in_first = (i % 8 == 0);
      #1 chk("t6_ready", rdy0, 1'b1);
      @(posedge clk); #1;
      if (ov0) pulses++;
      chk("t6_ov", ov0, i % 8 == 7);
    end
    in_valid = 0; in_first = 0;
    chk("t6_a", a0, {8'd54, 8'd52, 8'd50, 8'd48});
    @(posedge clk); #1;
    chk("t6_ov_end", ov0, 1'b0);
    chk("t6_pulses", pulses, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
